// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core: one shared req/ack memory port for fetch and data,
// FSM-sequenced datapath with a 32x32 register file.
module mips_multicycle_core #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]           SP_INIT    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  retire,
  output logic                  halt,
  output logic [ADDR_WIDTH-1:0] dbg_pc,
  output logic [3:0]            dbg_state
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [31:0]           ir_reg, ir_next, a_reg, a_next, b_reg, b_next;
  logic [31:0]           alu_out_reg, alu_out_next, mdr_reg, mdr_next;
  logic                  mem_req_reg, mem_req_next, mem_we_reg, mem_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]           mem_wdata_reg, mem_wdata_next;
  logic                  retire_reg, retire_next, halt_reg, halt_next;
  logic [31:0]           rf_reg [32];
  logic [31:0]           rf_wen;
  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [31:0]           rf_wdata;

  logic        ack, funct_ok, unused_shamt;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, pc32, alu_result;

  assign ack          = mem_ack & mem_req_reg;
  assign opcode       = ir_reg[31:26];
  assign rs           = ir_reg[25:21];
  assign rt           = ir_reg[20:16];
  assign rd           = ir_reg[15:11];
  assign funct        = ir_reg[5:0];
  assign unused_shamt = ^ir_reg[10:6];
  assign imm_sext     = {{16{ir_reg[15]}}, ir_reg[15:0]};
  assign pc32         = 32'(pc_reg);
  assign funct_ok     = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  always_comb begin
    case (funct)
      6'h20:   alu_result = a_reg + b_reg;
      6'h22:   alu_result = a_reg - b_reg;
      6'h24:   alu_result = a_reg & b_reg;
      6'h25:   alu_result = a_reg | b_reg;
      6'h2A:   alu_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:  if (ack) state_next = DECODE;
      DECODE: begin
        case (opcode)
          6'h00:        state_next = funct_ok ? EXEC : HALT;
          6'h23, 6'h2B: state_next = MEMADR;
          6'h04:        state_next = BRANCH;
          6'h08:        state_next = ADDIEX;
          6'h02:        state_next = JUMP;
          default:      state_next = HALT;
        endcase
      end
      MEMADR: state_next = (opcode == 6'h23) ? MEMRD : MEMWR;
      MEMRD:  if (ack) state_next = MEMWB;
      MEMWR:  if (ack) state_next = FETCH;
      EXEC:   state_next = ALUWB;
      ADDIEX: state_next = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_next = FETCH;
      default: state_next = HALT;
    endcase
  end

  always_comb begin
    pc_next        = pc_reg;
    ir_next        = ir_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    alu_out_next   = alu_out_reg;
    mdr_next       = mdr_reg;
    rf_we          = 1'b0;
    rf_waddr       = rt;
    rf_wdata       = alu_out_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    case (state_reg)
      FETCH: if (ack) begin
        ir_next = mem_rdata;
        pc_next = pc_reg + ADDR_WIDTH'(4);
      end
      DECODE: begin
        a_next       = rf_reg[rs];
        b_next       = rf_reg[rt];
        alu_out_next = pc32 + {imm_sext[29:0], 2'b00};
      end
      MEMADR, ADDIEX: alu_out_next = a_reg + imm_sext;
      MEMRD:  if (ack) mdr_next = mem_rdata;
      MEMWB:  begin rf_we = 1'b1; rf_wdata = mdr_reg; end
      EXEC:   alu_out_next = alu_result;
      ALUWB:  begin rf_we = 1'b1; rf_waddr = rd; end
      ADDIWB: rf_we = 1'b1;
      BRANCH: if (a_reg == b_reg) pc_next = ADDR_WIDTH'(alu_out_reg);
      JUMP:   pc_next = ADDR_WIDTH'({pc32[31:28], ir_reg[25:0], 2'b00});
      default: ;
    endcase
    // A new request is launched only once the current one (if any) is acked,
    // so the port holds steady across wait states.
    if (!mem_req_reg || ack) begin
      mem_req_next   = state_next inside {FETCH, MEMRD, MEMWR};
      mem_we_next    = (state_next == MEMWR);
      mem_addr_next  = (state_next == FETCH) ? pc_next : ADDR_WIDTH'(alu_out_next);
      mem_wdata_next = b_next;
    end
    retire_next = (state_reg inside {MEMWB, ALUWB, ADDIWB, BRANCH, JUMP}) ||
                  (state_reg == MEMWR && ack);
    halt_next   = (state_next == HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg        <= RESET_PC;
      ir_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      alu_out_reg   <= '0;
      mdr_reg       <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      retire_reg    <= 1'b0;
      halt_reg      <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      ir_reg        <= ir_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      alu_out_reg   <= alu_out_next;
      mdr_reg       <= mdr_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      retire_reg    <= retire_next;
      halt_reg      <= halt_next;
    end
  end

  // $0 never gets a write enable, so it stays at its reset value of zero.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rf_wen
      assign rf_wen[gi] = rf_we && (rf_waddr == 5'(gi)) && (gi != 0);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_reg[i] <= (i == 29) ? SP_INIT : 32'd0;
    end else begin
      for (int i = 0; i < 32; i++) if (rf_wen[i]) rf_reg[i] <= rf_wdata;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign retire    = retire_reg;
  assign halt      = halt_reg;
  assign dbg_pc    = pc_reg;
  assign dbg_state = state_reg;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: behavioural memory with programmable wait
// states, store and retire-latency scoreboards, directed programs.
module tb_mips_multicycle_core;

  localparam int          AW      = 12;
  localparam logic [31:0] SP_VAL  = 32'h0000_0ABC;
  localparam logic [31:0] HALT_W  = 32'hFC00_0000;

  logic          clk, reset;
  logic          mem_req, mem_we, mem_ack, retire, halt;
  logic [AW-1:0] mem_addr, dbg_pc;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    dbg_state;

  mips_multicycle_core #(.ADDR_WIDTH(AW), .RESET_PC(12'h000), .SP_INIT(SP_VAL)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .retire(retire), .halt(halt),
    .dbg_pc(dbg_pc), .dbg_state(dbg_state)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

  logic [31:0] imem [1024];
  logic [31:0] dmem [int];
  st_t         exp_st [$];
  int          exp_lat [$];
  int          tests_run = 0, tests_failed = 0;
  int          wait_cycles = 0, retire_cnt = 0, cyc = 0, last_retire = 0;
  bit          skip_first = 1, first_emit = 1;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else
      $display("[TB] ok   %s = 0x%08h", tag, got);
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  // Loads one instruction and queues its expected retire-to-retire latency.
  task automatic emit(input logic [11:0] addr, input logic [31:0] w, input int base, input int acc);
    imem[addr[11:2]] = w;
    if (first_emit) first_emit = 0;
    else exp_lat.push_back(base + acc * wait_cycles);
  endtask

  task automatic exp_store(input logic [31:0] a, input logic [31:0] d);
    st_t s;
    s.addr = a; s.data = d;
    exp_st.push_back(s);
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic start_phase(input int w);
    reset = 0;
    skip_first = 1;
    first_emit = 1;
    exp_lat.delete();
    exp_st.delete();
    wait_cycles = w;
    for (int i = 0; i < 1024; i++) imem[i] = HALT_W;
    tick;
    tick;
  endtask

  task automatic wait_retires(input int n, input int budget);
    int start, t;
    start = retire_cnt;
    t = 0;
    while (retire_cnt - start < n && t < budget) begin tick; t++; end
    if (retire_cnt - start < n) check_eq("retire_timeout", 32'(retire_cnt - start), 32'(n));
  endtask

  task automatic wait_halt(input int budget);
    int t;
    t = 0;
    while (!halt && t < budget) begin tick; t++; end
    if (!halt) check_eq("halt_timeout", 32'(halt), 32'd1);
  endtask

  task automatic wait_req(input int budget);
    int t;
    t = 0;
    while (!mem_req && t < budget) begin tick; t++; end
    if (!mem_req) check_eq("req_timeout", 32'(mem_req), 32'd1);
  endtask

  // Memory responder: acks after wait_cycles idle request cycles.
  initial begin
    int          wait_cnt;
    int          idx;
    logic [AW-1:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_we, unstable;
    st_t         s;
    wait_cnt = 0;
    unstable = 0;
    mem_ack = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 0;
      if (!reset || !mem_req) begin
        wait_cnt = 0;
        if (!reset) dmem.delete();
      end else begin
        if (wait_cnt == 0) begin
          cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata; unstable = 0;
        end else if (mem_addr !== cap_addr || mem_we !== cap_we ||
                     (mem_we && mem_wdata !== cap_wdata))
          unstable = 1;
        if (wait_cnt >= wait_cycles) begin
          mem_ack = 1;
          wait_cnt = 0;
          idx = int'(mem_addr[11:2]);
          if (mem_we) begin
            $display("[TB] store addr=0x%03h data=0x%08h", mem_addr, mem_wdata);
            check_eq("store_stable", 32'(unstable), 32'd0);
            if (exp_st.size() == 0) check_eq("store_unexpected", 32'd1, 32'd0);
            else begin
              s = exp_st.pop_front();
              check_eq("store_addr", 32'(mem_addr), s.addr);
              check_eq("store_data", mem_wdata, s.data);
            end
            dmem[idx] = mem_wdata;
          end else
            mem_rdata = dmem.exists(idx) ? dmem[idx] : imem[idx];
        end else
          wait_cnt++;
      end
    end
  end

  // Retire monitor: checks latency between consecutive retire pulses.
  initial begin
    int lat;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset && retire) begin
        retire_cnt++;
        if (halt) check_eq("retire_in_halt", 32'(retire), 32'd0);
        if (skip_first) skip_first = 0;
        else if (exp_lat.size() == 0) check_eq("retire_extra", 32'd1, 32'd0);
        else begin
          lat = exp_lat.pop_front();
          check_eq("retire_latency", 32'(cyc - last_retire), 32'(lat));
        end
        last_retire = cyc;
      end
    end
  end

  initial begin
    int  rc;
    bit  req_seen;
    reset = 0;

    // Phase A: zero-wait ALU/store/branch/jump program ending in an illegal opcode.
    start_phase(0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_retire", 32'(retire), 32'd0);
    check_eq("rst_halt", 32'(halt), 32'd0);
    check_eq("rst_pc", 32'(dbg_pc), 32'h000);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    emit(12'h000, enc_i(6'h08, 0, 1, 5), 4, 1);
    emit(12'h004, enc_i(6'h08, 0, 2, -3), 4, 1);
    emit(12'h008, enc_r(1, 2, 3, 6'h20), 4, 1);
    emit(12'h00C, enc_r(2, 1, 4, 6'h2A), 4, 1);
    emit(12'h010, enc_i(6'h2B, 0, 3, 32'h100), 4, 2);  exp_store(32'h100, 32'd2);
    emit(12'h014, enc_i(6'h2B, 0, 4, 32'h104), 4, 2);  exp_store(32'h104, 32'd1);
    emit(12'h018, enc_i(6'h2B, 0, 29, 32'h108), 4, 2); exp_store(32'h108, SP_VAL);
    emit(12'h01C, enc_r(2, 1, 6, 6'h22), 4, 1);
    emit(12'h020, enc_r(1, 2, 7, 6'h24), 4, 1);
    emit(12'h024, enc_r(1, 2, 8, 6'h25), 4, 1);
    emit(12'h028, enc_r(1, 2, 9, 6'h2A), 4, 1);
    emit(12'h02C, enc_i(6'h2B, 0, 6, 32'h10C), 4, 2);  exp_store(32'h10C, 32'hFFFF_FFF8);
    emit(12'h030, enc_i(6'h2B, 0, 7, 32'h110), 4, 2);  exp_store(32'h110, 32'd5);
    emit(12'h034, enc_i(6'h2B, 0, 8, 32'h114), 4, 2);  exp_store(32'h114, 32'hFFFF_FFFD);
    emit(12'h038, enc_i(6'h2B, 0, 9, 32'h118), 4, 2);  exp_store(32'h118, 32'd0);
    emit(12'h03C, enc_r(1, 1, 0, 6'h20), 4, 1);
    emit(12'h040, enc_i(6'h2B, 0, 0, 32'h11C), 4, 2);  exp_store(32'h11C, 32'd0);
    emit(12'h044, enc_i(6'h04, 1, 2, 5), 3, 1);
    emit(12'h048, enc_i(6'h2B, 0, 1, 32'h120), 4, 2);  exp_store(32'h120, 32'd5);
    emit(12'h04C, enc_j(26'h3FC), 3, 1);
    emit(12'hFF0, enc_j(26'h3FF_FFFF), 3, 1);
    emit(12'hFFC, enc_i(6'h04, 0, 0, 21), 3, 1);
    emit(12'h054, enc_i(6'h2B, 0, 1, 32'h124), 4, 2);  exp_store(32'h124, 32'd5);
    rc = retire_cnt;
    reset = 1;
    wait_halt(2000);
    check_eq("A_halt", 32'(halt), 32'd1);
    check_eq("A_halt_pc", 32'(dbg_pc), 32'h05C);
    check_eq("A_halt_state", 32'(dbg_state), 32'd12);
    check_eq("A_retires", 32'(retire_cnt - rc), 32'd23);
    rc = retire_cnt;
    req_seen = 0;
    repeat (10) begin tick; if (mem_req) req_seen = 1; end
    check_eq("A_halt_no_req", 32'(req_seen), 32'd0);
    check_eq("A_halt_no_retire", 32'(retire_cnt - rc), 32'd0);
    check_eq("A_stores_left", 32'(exp_st.size()), 32'd0);
    check_eq("A_lat_left", 32'(exp_lat.size()), 32'd0);

    // Phase B: 3 wait states on every access, store/load round trip, beq loop.
    start_phase(3);
    check_eq("B_halt_cleared", 32'(halt), 32'd0);
    emit(12'h000, enc_i(6'h08, 0, 3, 2), 4, 1);
    emit(12'h004, enc_i(6'h2B, 0, 3, 32'h208), 4, 2); exp_store(32'h208, 32'd2);
    emit(12'h008, enc_i(6'h23, 0, 5, 32'h208), 5, 2);
    emit(12'h00C, enc_i(6'h2B, 0, 5, 32'h20C), 4, 2); exp_store(32'h20C, 32'd2);
    emit(12'h010, enc_i(6'h04, 1, 1, -1), 3, 1);
    exp_lat.push_back(3 + wait_cycles);
    exp_lat.push_back(3 + wait_cycles);
    reset = 1;
    wait_retires(4, 400);
    for (int k = 0; k < 3; k++) begin
      wait_retires(1, 100);
      check_eq("B_loop_pc", 32'(dbg_pc), 32'h010);
    end
    check_eq("B_stores_left", 32'(exp_st.size()), 32'd0);
    check_eq("B_lat_left", 32'(exp_lat.size()), 32'd0);

    // Phase C: 1 wait state, write to $0 discarded, beq not taken, halt.
    start_phase(1);
    emit(12'h000, enc_i(6'h08, 0, 2, 1), 4, 1);
    emit(12'h004, enc_r(2, 2, 0, 6'h20), 4, 1);
    emit(12'h008, enc_i(6'h2B, 0, 0, 32'h300), 4, 2); exp_store(32'h300, 32'd0);
    emit(12'h00C, enc_i(6'h08, 0, 1, 0), 4, 1);
    emit(12'h010, enc_i(6'h04, 1, 2, -1), 3, 1);
    reset = 1;
    wait_retires(5, 400);
    check_eq("C_beq_nt_pc", 32'(dbg_pc), 32'h014);
    wait_halt(100);
    check_eq("C_halt", 32'(halt), 32'd1);
    check_eq("C_stores_left", 32'(exp_st.size()), 32'd0);

    // Phase D: reset exits HALT, then reset abandons a pending fetch.
    reset = 0;
    skip_first = 1;
    exp_lat.delete();
    tick;
    check_eq("D_halt_reset", 32'(halt), 32'd0);
    check_eq("D_pc_reset", 32'(dbg_pc), 32'h000);
    wait_cycles = 20;
    reset = 1;
    wait_req(20);
    check_eq("D_first_we", 32'(mem_we), 32'd0);
    check_eq("D_first_addr", 32'(mem_addr), 32'h000);
    repeat (3) tick;
    check_eq("D_req_pending", 32'(mem_req), 32'd1);
    reset = 0;
    #1;
    check_eq("D_req_dropped", 32'(mem_req), 32'd0);
    check_eq("D_state_fetch", 32'(dbg_state), 32'd0);
    tick;
    tick;
    wait_cycles = 0;
    skip_first = 1;
    reset = 1;
    wait_req(20);
    check_eq("D_refetch_we", 32'(mem_we), 32'd0);
    check_eq("D_refetch_addr", 32'(mem_addr), 32'h000);
    reset = 0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multicycle successor to the single-cycle MIPS datapath.
- Shares one memory port between instruction fetch and data access. That port uses a req/ack handshake, so wait states are tolerated.
- Sequences each instruction through an FSM. Contains the PC, IR, register file (32 x 32), ALU and datapath holding registers.
- Exposes retire/halt/debug outputs for the bench.

Parameters:
ADDR_WIDTH, 32, width of PC and mem_addr (12..32); PC arithmetic wraps modulo 2^ADDR_WIDTH
RESET_PC, 0, PC value loaded on reset (word aligned)
SP_INIT, 0, reset value of register $29; all other registers reset to 0

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_req  output  1  memory request, held until acknowledged
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_addr  output  ADDR_WIDTH  byte address; valid while mem_req
mem_wdata  output  32  store data; valid while mem_req && mem_we
mem_ack  input  1  request accepted/completed this cycle
mem_rdata  input  32  read data; valid in the mem_ack cycle of a read
retire  output  1  one-cycle pulse when an instruction completes
halt  output  1  high in HALT state (illegal opcode or funct)
dbg_pc  output  ADDR_WIDTH  current PC
dbg_state  output  4  FSM state encoding

Behaviour:
- Reset (reset=0, async): state=FETCH, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, regs=0 except $29=SP_INIT, mem_req=0, mem_we=0, retire=0, halt=0. Reset mid-transaction drops mem_req immediately; that transaction is abandoned.
- Handshake:
  - mem_req/mem_we/mem_addr/mem_wdata are registered and stable from assertion until the cycle mem_ack=1 is sampled.
  - ack in the first req cycle is legal (zero wait).
  - mem_req deasserts the cycle after ack unless the next state issues a new request.
  - mem_ack with mem_req=0 is ignored.
- Supported instructions: R-type funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); opcodes lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02. Anything else goes to HALT in DECODE.
- FSM states and transitions:
  - FETCH: read at PC. On ack, IR<=rdata and PC<=PC+4, then go to DECODE.
  - DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(signext(imm)<<2). Dispatch by opcode.
  - MEMADR: ALUOut<=A+signext(imm). Go to MEMRD (lw) or MEMWR (sw).
  - MEMRD: read ALUOut. On ack, MDR<=rdata, then go to MEMWB.
  - MEMWB: R[rt]<=MDR, retire, then FETCH.
  - MEMWR: write B to ALUOut. On ack, retire, then FETCH.
  - EXEC: ALUOut<=A op B, then ALUWB.
  - ALUWB: R[rd]<=ALUOut, retire, then FETCH.
  - ADDIEX: ALUOut<=A+signext(imm), then ADDIWB.
  - ADDIWB: R[rt]<=ALUOut, retire, then FETCH.
  - BRANCH: if A==B, PC<=ALUOut. Retire, then FETCH.
  - JUMP: PC<={PC[ADDR_WIDTH-1:28], imm26, 2'b00}, truncated to ADDR_WIDTH if ADDR_WIDTH<=28. Retire, then FETCH.
  - HALT: terminal. halt=1, no memory requests; only reset exits.
- Latency with zero-wait memory, in cycles, counted from FETCH entry to retire inclusive: R-type 4, addi 4, sw 4, lw 5, beq 3, j 3. Each wait cycle on a memory state adds 1.
- Register file:
  - $0 always reads 0; writes to $0 are discarded.
  - Writes occur at the clock edge ending the writeback state.
  - DECODE reads see the writeback of the previous instruction.
- Arithmetic: 32-bit two's complement; add/sub/addi wrap with no overflow trap. slt yields 1/0 in bit 0.
- Addresses:
  - PC+4 and branch targets wrap modulo 2^ADDR_WIDTH.
  - Data address is ALUOut[ADDR_WIDTH-1:0], driven unaltered.
  - Misaligned addresses are not checked; the memory ignores bits [1:0].
- retire is registered and high for exactly one cycle per completed instruction; it is never high in HALT.

Test Plan:
1. Zero-wait memory: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> $3=2, $4=1, retire pulses at cycles 4, 8, 12, 16.
2. sw $3,8($0) then lw $5,8($0) with mem_ack delayed 3 cycles on every request -> write to addr 0x8 with wdata=2, held stable through the wait cycles; $5=2; the lw takes 5+6=11 cycles.
3. beq $1,$1,-1 at PC=0x10 -> PC returns to 0x10 (3-cycle loop). With beq $1,$2 (not equal) -> PC=0x14.
4. j 0x3FFFFFF with ADDR_WIDTH=12, PC=0xFF0 -> PC=0xFFC. Then fetch at 0xFFC; PC+4 wraps to 0x000.
5. Opcode 0x3F fetched -> halt=1 after DECODE, mem_req stays 0, no retire. reset pulse -> PC=RESET_PC, halt=0.
6. Assert reset while mem_req=1 awaiting ack -> mem_req=0 immediately; after release, first request is a read at RESET_PC; $0 write via add $0,$1,$1 -> $0 still reads 0.
